wb_pipe_stage: RTL
==================

Name: wb_pipe_stage

Overview:
- Parametrised MEM->WB pipeline stage with valid/ready handshake.
- Sits between the memory stage and the register-file/CSR write ports.
- Generalises the plain hold-enabled writeback register in four ways:
  - configurable payload widths;
  - a DEPTH-entry skid buffer, so upstream is not stalled combinationally by hold;
  - a flush input;
  - exactly-once write strobes and an accurate retire pulse.

Parameters:
- INST_W, 32, instruction width.
- IADDR_W, 32, instruction address width.
- RADDR_W, 5, GPR address width.
- RDATA_W, 32, GPR data width.
- CADDR_W, 12, CSR address width.
- CDATA_W, 32, CSR data width.
- DEPTH, 2, skid buffer entries. Legal values are 1 and 2.
- NOP_INST, 32'h00000013, instruction presented when the stage is empty.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- in_valid_i  in  1  memory stage presents an instruction.
- in_ready_o  out  1  stage can accept.
- inst_i  in  INST_W  instruction.
- instaddr_i  in  IADDR_W  instruction PC.
- regs_wen_i  in  1  GPR write request.
- rd_addr_i  in  RADDR_W  GPR destination.
- rd_data_i  in  RDATA_W  GPR write data.
- csr_wen_i  in  1  CSR write request.
- csr_wr_addr_i  in  CADDR_W  CSR address.
- csr_wr_data_i  in  CDATA_W  CSR write data.
- hold_i  in  1  ctrl stall of writeback.
- flush_i  in  1  ctrl kill of all buffered entries.
- out_valid_o  out  1  head entry valid.
- inst_o  out  INST_W  head instruction, or NOP_INST when empty.
- instaddr_o  out  IADDR_W  head PC, or 0 when empty.
- regs_wen_o  out  1  GPR write strobe.
- rd_addr_o  out  RADDR_W  head GPR destination.
- rd_data_o  out  RDATA_W  head GPR write data.
- csr_wen_o  out  1  CSR write strobe.
- csr_wr_addr_o  out  CADDR_W  head CSR address.
- csr_wr_data_o  out  CDATA_W  head CSR write data.
- instret_incr_o  out  1  one-cycle retire pulse.
- count_o  out  2  occupancy.

Behaviour:
- Single clock `clk`. Reset `rstn` is asynchronous and active-low.
- Reset state: all entries invalid, count 0, read and write pointers 0.
- Reset output values: out_valid_o=0, inst_o=NOP_INST, every other output 0, in_ready_o=1 (once rstn is released).
- Storage is a circular buffer of DEPTH entries. Each entry holds the full payload; its valid state is implied by count.
- in_ready_o = (count < DEPTH). It is derived from registers only. There is no combinational path from hold_i or flush_i to in_ready_o.
- push = in_valid_i & in_ready_o & !flush_i.
- pop = out_valid_o & !hold_i & !flush_i.
- out_valid_o = (count != 0).
- Latency: an entry accepted at edge N appears on the outputs after edge N (one cycle), if the buffer was empty.
- Payload outputs are driven from the head entry when out_valid_o=1.
- When the stage is empty: inst_o=NOP_INST and all other payload outputs are 0.
- regs_wen_o = out_valid_o & head.regs_wen & (head.rd_addr != 0) & !hold_i & !flush_i. A write to x0 is never strobed.
- csr_wen_o = out_valid_o & head.csr_wen & !hold_i & !flush_i.
- Each buffered instruction therefore produces write strobes in exactly one cycle: the cycle in which it is popped.
- instret_incr_o = pop. This is combinational, one pulse per retired instruction, and never pulses for bubbles.
- Pointers:
  - push writes at wr_ptr, then wr_ptr advances modulo DEPTH.
  - pop advances rd_ptr modulo DEPTH.
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged.
- Full (count==DEPTH): in_ready_o=0. Upstream must hold its payload; pop may still occur.
- Empty with push: no bypass. The new entry becomes visible next cycle.
- flush_i=1 at an edge:
  - count, wr_ptr and rd_ptr reset to 0;
  - the concurrent input is dropped;
  - no strobe and no instret pulse in that cycle.
- flush_i has priority over hold_i and in_valid_i.
- hold_i=1: head entry and outputs are frozen, strobes are 0, pushes continue while in_ready_o=1.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronously) and outputs go to their reset values.
- Stored payload registers need no reset. Only count and the pointers are reset.

Test Plan:
- Reset, then push inst=0x00500093, rd=1, data=5, regs_wen=1 with hold=0 -> next cycle:
  - out_valid=1, regs_wen_o=1, rd_addr_o=1, rd_data_o=5, instret_incr_o=1;
  - the cycle after: out_valid=0, inst_o=0x00000013.
- hold=1 for 3 cycles while pushing A then B (DEPTH=2) -> count reaches 2, in_ready_o=0, no strobes and no instret. On hold release, A then B retire on consecutive cycles with one instret pulse each.
- Back-to-back stream of 10 instructions with hold=0 -> 10 instret pulses, each GPR strobe once, in_ready_o constantly 1.
- Entry with rd_addr=0 and regs_wen=1 -> regs_wen_o stays 0, instret_incr_o=1.
- Two entries buffered, flush=1 together with in_valid=1 -> next cycle count=0 and out_valid=0. No strobes for any of the three instructions.
- Assert rstn=0 asynchronously mid-cycle while count=2 -> outputs return to reset values without a clock edge. After release, in_ready_o=1.

Source files
------------

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage: DEPTH-entry skid buffer with valid/ready handshake,
// flush, exactly-once GPR/CSR write strobes and a retire pulse per instruction.
module wb_pipe_stage #(
  parameter int unsigned INST_W   = 32,
  parameter int unsigned IADDR_W  = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned RDATA_W  = 32,
  parameter int unsigned CADDR_W  = 12,
  parameter int unsigned CDATA_W  = 32,
  parameter int unsigned DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INST_W-1:0]  inst_i,
  input  logic [IADDR_W-1:0] instaddr_i,
  input  logic               regs_wen_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic [RDATA_W-1:0] rd_data_i,
  input  logic               csr_wen_i,
  input  logic [CADDR_W-1:0] csr_wr_addr_i,
  input  logic [CDATA_W-1:0] csr_wr_data_i,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  output logic [INST_W-1:0]  inst_o,
  output logic [IADDR_W-1:0] instaddr_o,
  output logic               regs_wen_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic [RDATA_W-1:0] rd_data_o,
  output logic               csr_wen_o,
  output logic [CADDR_W-1:0] csr_wr_addr_o,
  output logic [CDATA_W-1:0] csr_wr_data_o,
  output logic               instret_incr_o,
  output logic [1:0]         count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]       DEPTH_C  = 2'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [1:0]       count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Payload storage; validity is implied by count, so no reset is needed.
  logic [INST_W-1:0]  inst_q     [DEPTH];
  logic [IADDR_W-1:0] instaddr_q [DEPTH];
  logic               regs_wen_q [DEPTH];
  logic [RADDR_W-1:0] rd_addr_q  [DEPTH];
  logic [RDATA_W-1:0] rd_data_q  [DEPTH];
  logic               csr_wen_q  [DEPTH];
  logic [CADDR_W-1:0] csr_addr_q [DEPTH];
  logic [CDATA_W-1:0] csr_data_q [DEPTH];

  logic ready_c;
  logic valid_c;
  logic push_c;
  logic pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake terms; ready depends on registered occupancy only.
  always_comb begin
    ready_c = (count_q < DEPTH_C);
    valid_c = (count_q != 2'd0);
    push_c  = in_valid_i & ready_c & ~flush_i;
    pop_c   = valid_c & ~hold_i & ~flush_i;
  end

  // Pointer and occupancy next state; flush wins over everything.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q  <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      inst_q[wr_ptr_q]     <= inst_i;
      instaddr_q[wr_ptr_q] <= instaddr_i;
      regs_wen_q[wr_ptr_q] <= regs_wen_i;
      rd_addr_q[wr_ptr_q]  <= rd_addr_i;
      rd_data_q[wr_ptr_q]  <= rd_data_i;
      csr_wen_q[wr_ptr_q]  <= csr_wen_i;
      csr_addr_q[wr_ptr_q] <= csr_wr_addr_i;
      csr_data_q[wr_ptr_q] <= csr_wr_data_i;
    end
  end

  // Head presentation; strobes only fire in the cycle the head is popped.
  always_comb begin
    in_ready_o     = ready_c;
    out_valid_o    = valid_c;
    count_o        = count_q;
    instret_incr_o = pop_c;
    inst_o         = NOP_INST;
    instaddr_o     = '0;
    regs_wen_o     = 1'b0;
    rd_addr_o      = '0;
    rd_data_o      = '0;
    csr_wen_o      = 1'b0;
    csr_wr_addr_o  = '0;
    csr_wr_data_o  = '0;
    if (valid_c) begin
      inst_o        = inst_q[rd_ptr_q];
      instaddr_o    = instaddr_q[rd_ptr_q];
      rd_addr_o     = rd_addr_q[rd_ptr_q];
      rd_data_o     = rd_data_q[rd_ptr_q];
      csr_wr_addr_o = csr_addr_q[rd_ptr_q];
      csr_wr_data_o = csr_data_q[rd_ptr_q];
      regs_wen_o    = pop_c & regs_wen_q[rd_ptr_q] & (rd_addr_q[rd_ptr_q] != '0);
      csr_wen_o     = pop_c & csr_wen_q[rd_ptr_q];
    end
  end

endmodule
